// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_arbiter
// Description : Shares one byte-level I2C master engine between NREQ local
//               requesters. Round-robin arbitration, then sequences the
//               granted transaction: START, address+R/W, 0..2^LENW-1 data
//               bytes, STOP, with ACK/NACK handling.
// Ports       : clk/reset            - system clock, sync active-high reset
//               req/req_addr/req_rw/req_len/datasend - per-requester inputs
//               sended/received/datareceive/grant/done/nack - requester side
//               eng_valid/eng_cmd/eng_wdata/eng_rack - command to engine
//               eng_ready/eng_done/eng_rdata/eng_ack - engine handshake/result
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter #(
    parameter int NREQ = 4,
    parameter int LENW = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [7*NREQ-1:0]      req_addr,
    input  logic [NREQ-1:0]        req_rw,
    input  logic [LENW*NREQ-1:0]   req_len,
    input  logic [8*NREQ-1:0]      datasend,
    output logic [NREQ-1:0]        sended,
    output logic [7:0]             datareceive,
    output logic [NREQ-1:0]        received,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic                   nack,
    output logic                   eng_valid,
    output logic [1:0]             eng_cmd,
    output logic [7:0]             eng_wdata,
    output logic                   eng_rack,
    input  logic                   eng_ready,
    input  logic                   eng_done,
    input  logic [7:0]             eng_rdata,
    input  logic                   eng_ack
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ARB   = 3'd1;
    localparam logic [2:0] c_START = 3'd2;
    localparam logic [2:0] c_ADDR  = 3'd3;
    localparam logic [2:0] c_DATA  = 3'd4;
    localparam logic [2:0] c_STOP  = 3'd5;
    localparam logic [2:0] c_FIN   = 3'd6;

    localparam logic [1:0] c_CMD_START = 2'd0;
    localparam logic [1:0] c_CMD_WRITE = 2'd1;
    localparam logic [1:0] c_CMD_READ  = 2'd2;
    localparam logic [1:0] c_CMD_STOP  = 2'd3;

    localparam logic [PW:0] c_NREQ = (PW+1)'(NREQ);

    logic [2:0]      r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [6:0]      r_addr;
    logic            r_rw;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_cnt;
    logic            r_nack;
    // Set once the current command has been accepted; eng_done only counts
    // while this is high, so stray completions before the handshake are ignored.
    logic            r_issued;

    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_next_ptr;
    logic [6:0]      w_win_addr;
    logic            w_win_rw;
    logic [LENW-1:0] w_win_len;
    logic [NREQ-1:0] w_win_oh;
    logic [NREQ-1:0] w_owner_oh;
    logic [7:0]      w_owner_byte;
    logic [1:0]      w_cmd;
    logic [7:0]      w_wdata;
    logic            w_rack;

    // (base + inc) mod NREQ; inc is always below NREQ so one subtraction suffices.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                               input logic [PW:0]   inc);
        logic [PW:0] s;
        s = {1'b0, base} + inc;
        if (s >= c_NREQ)
            s = s - c_NREQ;
        return s[PW-1:0];
    endfunction

    // Round-robin search: first set request at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[wrap_add(r_ptr, (PW+1)'(k))]) begin
                w_found = 1'b1;
                w_win   = wrap_add(r_ptr, (PW+1)'(k));
            end
        end
        w_next_ptr = wrap_add(w_win, (PW+1)'(1));
    end

    // Per-requester field selection for the winner and the current owner.
    always_comb begin
        w_win_addr   = '0;
        w_win_rw     = 1'b0;
        w_win_len    = '0;
        w_win_oh     = '0;
        w_owner_oh   = '0;
        w_owner_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PW'(i)) begin
                w_win_addr  = req_addr[7*i +: 7];
                w_win_rw    = req_rw[i];
                w_win_len   = req_len[LENW*i +: LENW];
                w_win_oh[i] = 1'b1;
            end
            if (r_owner == PW'(i)) begin
                w_owner_byte  = datasend[8*i +: 8];
                w_owner_oh[i] = 1'b1;
            end
        end
    end

    // Command contents for the current command state.
    always_comb begin
        w_cmd   = c_CMD_START;
        w_wdata = '0;
        w_rack  = 1'b0;
        case (r_state)
            c_ADDR: begin
                w_cmd   = c_CMD_WRITE;
                w_wdata = {r_addr, r_rw};
            end
            c_DATA: begin
                if (r_rw) begin
                    w_cmd  = c_CMD_READ;
                    // NACK the final read byte so the slave releases the bus.
                    w_rack = (r_cnt == LENW'(1));
                end else begin
                    w_cmd   = c_CMD_WRITE;
                    w_wdata = w_owner_byte;
                end
            end
            c_STOP:  w_cmd = c_CMD_STOP;
            default: w_cmd = c_CMD_START;
        endcase
    end

    assign nack = r_nack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_nack      <= 1'b0;
            r_issued    <= 1'b0;
            grant       <= '0;
            done        <= '0;
            sended      <= '0;
            received    <= '0;
            datareceive <= '0;
            eng_valid   <= 1'b0;
            eng_cmd     <= '0;
            eng_wdata   <= '0;
            eng_rack    <= 1'b0;
        end else begin
            sended   <= '0;
            received <= '0;
            done     <= '0;
            case (r_state)
                c_IDLE: begin
                    if (|req)
                        r_state <= c_ARB;
                end
                c_ARB: begin
                    if (w_found) begin
                        r_owner  <= w_win;
                        r_addr   <= w_win_addr;
                        r_rw     <= w_win_rw;
                        r_len    <= w_win_len;
                        grant    <= w_win_oh;
                        r_ptr    <= w_next_ptr;
                        r_issued <= 1'b0;
                        r_state  <= c_START;
                    end else begin
                        // Request vanished between IDLE and ARB.
                        r_state <= c_IDLE;
                    end
                end
                c_START, c_ADDR, c_DATA, c_STOP: begin
                    if (!r_issued) begin
                        if (!eng_valid) begin
                            eng_valid <= 1'b1;
                            eng_cmd   <= w_cmd;
                            eng_wdata <= w_wdata;
                            eng_rack  <= w_rack;
                        end else if (eng_ready) begin
                            eng_valid <= 1'b0;
                            r_issued  <= 1'b1;
                        end
                    end else if (eng_done) begin
                        r_issued <= 1'b0;
                        case (r_state)
                            c_START: r_state <= c_ADDR;
                            c_ADDR: begin
                                if (eng_ack) begin
                                    r_nack  <= 1'b1;
                                    r_state <= c_STOP;
                                end else if (r_len == '0) begin
                                    r_state <= c_STOP;
                                end else begin
                                    r_cnt   <= r_len;
                                    r_state <= c_DATA;
                                end
                            end
                            c_DATA: begin
                                r_cnt <= r_cnt - LENW'(1);
                                if (r_rw) begin
                                    datareceive <= eng_rdata;
                                    received    <= w_owner_oh;
                                    if (r_cnt == LENW'(1))
                                        r_state <= c_STOP;
                                end else begin
                                    sended <= w_owner_oh;
                                    if (eng_ack) begin
                                        r_nack  <= 1'b1;
                                        r_state <= c_STOP;
                                    end else if (r_cnt == LENW'(1)) begin
                                        r_state <= c_STOP;
                                    end
                                end
                            end
                            c_STOP: begin
                                done    <= w_owner_oh;
                                r_state <= c_FIN;
                            end
                            default: r_state <= c_IDLE;
                        endcase
                    end
                end
                c_FIN: begin
                    grant   <= '0;
                    r_nack  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_master_arbiter
// Description : Self-checking bench for i2c_master_arbiter. A behavioural
//               engine and requester model drive the DUT; expected engine
//               commands and requester pulses are queued per transaction and
//               compared as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master_arbiter;

    localparam int NREQ = 4;
    localparam int LENW = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req;
    logic [7*NREQ-1:0]     req_addr;
    logic [NREQ-1:0]       req_rw;
    logic [LENW*NREQ-1:0]  req_len;
    logic [8*NREQ-1:0]     datasend;
    logic [NREQ-1:0]       sended;
    logic [7:0]            datareceive;
    logic [NREQ-1:0]       received;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic                  nack;
    logic                  eng_valid;
    logic [1:0]            eng_cmd;
    logic [7:0]            eng_wdata;
    logic                  eng_rack;
    logic                  eng_ready;
    logic                  eng_done;
    logic [7:0]            eng_rdata;
    logic                  eng_ack;

    always #5 clk = ~clk;

    i2c_master_arbiter #(.NREQ(NREQ), .LENW(LENW)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .req_rw      (req_rw),
        .req_len     (req_len),
        .datasend    (datasend),
        .sended      (sended),
        .datareceive (datareceive),
        .received    (received),
        .grant       (grant),
        .done        (done),
        .nack        (nack),
        .eng_valid   (eng_valid),
        .eng_cmd     (eng_cmd),
        .eng_wdata   (eng_wdata),
        .eng_rack    (eng_rack),
        .eng_ready   (eng_ready),
        .eng_done    (eng_done),
        .eng_rdata   (eng_rdata),
        .eng_ack     (eng_ack)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard queues. Command entries are {cmd, wdata, rack}.
    logic [10:0]      q_cmd[$];
    logic             q_ack[$];
    logic [7:0]       q_rdata[$];
    logic [NREQ-1:0]  q_snd[$];
    logic [NREQ+7:0]  q_rcv[$];
    logic [NREQ:0]    q_done[$];

    bit [7:0] wb[NREQ][16];
    bit [7:0] rb[NREQ][16];
    int       nack_at[NREQ];
    int       tx_left[NREQ];
    int       idx[NREQ];
    int       done_cnt = 0;
    int       snd_cnt  = 0;

    bit         busy;
    int         dly;
    logic [7:0] cur_rd;
    logic       cur_ack;
    logic       pv, pr;
    logic [10:0] pc;
    logic [10:0] ob;
    logic [NREQ:0] de;

    task automatic setreq(input int i, input logic [6:0] a, input logic rw,
                          input logic [LENW-1:0] len, input int nk);
        req_addr[7*i +: 7]       = a;
        req_rw[i]                = rw;
        req_len[LENW*i +: LENW]  = len;
        nack_at[i]               = nk;
    endtask

    // Builds the expected engine traffic and requester pulses for one transaction.
    task automatic push_expect(input int i);
        logic [NREQ-1:0] oh;
        logic [7:0]      a;
        logic            rw;
        int              len;
        bit              nk;
        oh     = '0;
        oh[i]  = 1'b1;
        rw     = req_rw[i];
        a      = {req_addr[7*i +: 7], rw};
        len    = int'(req_len[LENW*i +: LENW]);
        q_cmd.push_back({2'd0, 8'h00, 1'b0});
        q_cmd.push_back({2'd1, a, 1'b0});
        q_ack.push_back(nack_at[i] == 0);
        nk = (nack_at[i] == 0);
        if (!nk) begin
            for (int b = 0; b < len; b++) begin
                if (!rw) begin
                    q_cmd.push_back({2'd1, wb[i][b], 1'b0});
                    q_ack.push_back(nack_at[i] == b + 1);
                    q_snd.push_back(oh);
                    if (nack_at[i] == b + 1) begin
                        nk = 1'b1;
                        break;
                    end
                end else begin
                    q_cmd.push_back({2'd2, 8'h00, (b == len - 1)});
                    q_rdata.push_back(rb[i][b]);
                    q_rcv.push_back({oh, rb[i][b]});
                end
            end
        end
        q_cmd.push_back({2'd3, 8'h00, 1'b0});
        q_done.push_back({oh, nk});
    endtask

    task automatic wait_done(input int n);
        int c;
        c = 0;
        while (done_cnt < n && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done_count", done_cnt, n);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Engine + requester model and output monitor, all on the falling edge.
    initial begin
        eng_ready = 1'b0; eng_done = 1'b0; eng_rdata = '0; eng_ack = 1'b0;
        busy = 0; dly = 0; pv = 0; pr = 0; pc = '0; cur_rd = '0; cur_ack = 1'b0;
        datasend = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                q_cmd.delete(); q_ack.delete(); q_rdata.delete();
                q_snd.delete(); q_rcv.delete(); q_done.delete();
                busy = 0; eng_done = 1'b0; eng_ready = 1'b0; pv = 0;
                for (int i = 0; i < NREQ; i++) idx[i] = 0;
            end else begin
                if (pv && !pr)
                    chk("cmd_hold", {eng_valid, eng_cmd, eng_wdata, eng_rack}, {1'b1, pc});
                if (sended != '0) begin
                    if (q_snd.size() == 0) chk("sended_unexpected", sended, 32'hFFFF_FFFF);
                    else                   chk("sended", sended, q_snd.pop_front());
                    for (int i = 0; i < NREQ; i++) if (sended[i]) idx[i]++;
                    snd_cnt++;
                end
                if (received != '0) begin
                    if (q_rcv.size() == 0) chk("received_unexpected", {received, datareceive}, 32'hFFFF_FFFF);
                    else                   chk("received", {received, datareceive}, q_rcv.pop_front());
                end
                if (done != '0) begin
                    if (q_done.size() == 0) begin
                        chk("done_unexpected", {done, nack}, 32'hFFFF_FFFF);
                    end else begin
                        de = q_done.pop_front();
                        chk("done_nack", {done, nack}, de);
                        chk("grant_at_done", grant, de[NREQ:1]);
                    end
                    done_cnt++;
                    for (int i = 0; i < NREQ; i++) begin
                        if (done[i]) begin
                            idx[i] = 0;
                            tx_left[i]--;
                            if (tx_left[i] <= 0) req[i] = 1'b0;
                        end
                    end
                end
                // Engine: finish a busy command, then decide readiness.
                eng_done = 1'b0;
                if (busy) begin
                    if (dly == 0) begin
                        eng_done  = 1'b1;
                        eng_ack   = cur_ack;
                        eng_rdata = cur_rd;
                        busy      = 0;
                    end else begin
                        dly--;
                    end
                end
                eng_ready = !busy && ($urandom_range(0, 3) != 0);
                if (eng_valid && eng_ready) begin
                    case (eng_cmd)
                        2'd1:    ob = {eng_cmd, eng_wdata, 1'b0};
                        2'd2:    ob = {eng_cmd, 8'h00, eng_rack};
                        default: ob = {eng_cmd, 8'h00, 1'b0};
                    endcase
                    if (q_cmd.size() == 0) chk("cmd_unexpected", ob, 32'hFFFF_FFFF);
                    else                   chk("eng_cmd", ob, q_cmd.pop_front());
                    cur_ack = 1'b0;
                    if (eng_cmd == 2'd1 && q_ack.size() != 0)   cur_ack = q_ack.pop_front();
                    if (eng_cmd == 2'd2 && q_rdata.size() != 0) cur_rd  = q_rdata.pop_front();
                    busy = 1;
                    dly  = 1;
                end
                pv = eng_valid;
                pr = eng_ready;
                pc = {eng_cmd, eng_wdata, eng_rack};
            end
            for (int i = 0; i < NREQ; i++)
                datasend[8*i +: 8] = wb[i][idx[i] % 16];
        end
    end

    initial begin
        int c;
        int s0;
        req = '0; req_addr = '0; req_rw = '0; req_len = '0;
        for (int i = 0; i < NREQ; i++) begin
            nack_at[i] = -1; tx_left[i] = 0; idx[i] = 0;
        end
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_ctrl", {grant, done, nack, sended, received, eng_valid, eng_cmd, eng_rack}, 0);
        chk("reset_data", {eng_wdata, datareceive}, 0);
        reset = 1'b0;
        tick();

        // Write of two bytes from requester 1.
        wb[1][0] = 8'hA5; wb[1][1] = 8'h3C;
        setreq(1, 7'h50, 1'b0, 4'd2, -1);
        tx_left[1] = 1;
        push_expect(1);
        req[1] = 1'b1;
        tick();
        chk("t1_grant_lat1", grant, 4'b0000);
        tick();
        chk("t1_grant_lat2", grant, 4'b0010);
        wait_done(1);
        chk("t1_sended_cnt", snd_cnt, 2);
        tick();
        chk("t1_grant_clear", {grant, nack}, 0);

        // Read of three bytes from requester 2.
        rb[2][0] = 8'h11; rb[2][1] = 8'h22; rb[2][2] = 8'h33;
        setreq(2, 7'h68, 1'b1, 4'd3, -1);
        tx_left[2] = 1;
        push_expect(2);
        req[2] = 1'b1;
        wait_done(2);
        chk("t2_datareceive", datareceive, 8'h33);

        // Write of four bytes, slave NACKs the second data byte.
        wb[0][0] = 8'h01; wb[0][1] = 8'h02; wb[0][2] = 8'h03; wb[0][3] = 8'h04;
        setreq(0, 7'h21, 1'b0, 4'd4, 2);
        tx_left[0] = 1;
        s0 = snd_cnt;
        push_expect(0);
        req[0] = 1'b1;
        wait_done(3);
        chk("t3_sended_cnt", snd_cnt - s0, 2);

        // Address-only probe to an absent device.
        setreq(3, 7'h2A, 1'b0, 4'd0, 0);
        tx_left[3] = 1;
        push_expect(3);
        req[3] = 1'b1;
        wait_done(4);

        // Fairness: all four held for two transactions each.
        for (int i = 0; i < NREQ; i++) begin
            setreq(i, 7'(8'h10 + i), 1'b0, 4'd1, -1);
            wb[i][0] = 8'(8'h40 + i);
            tx_left[i] = 2;
        end
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++)
                push_expect(i);
        req = '1;
        c = 0;
        while (!(done_cnt >= 8 && grant[0]) && c < 3000) begin
            tick();
            c++;
        end
        chk("t5_second_grant0", {(done_cnt >= 8), grant}, {1'b1, 4'b0001});
        req[0] = 1'b0;   // dropped while granted; must still complete
        wait_done(12);

        // Reset in the middle of a data phase.
        wb[1][0] = 8'h71; wb[1][1] = 8'h72; wb[1][2] = 8'h73; wb[1][3] = 8'h74;
        setreq(1, 7'h33, 1'b0, 4'd4, -1);
        tx_left[1] = 1;
        push_expect(1);
        s0 = snd_cnt;
        req[1] = 1'b1;
        c = 0;
        while (snd_cnt == s0 && c < 3000) begin
            tick();
            c++;
        end
        chk("t6_in_data", (snd_cnt > s0), 1);
        reset = 1'b1;
        req   = '0;
        tick();
        chk("t6_rst_ctrl", {grant, done, nack, sended, received, eng_valid, eng_cmd, eng_rack}, 0);
        chk("t6_rst_data", {eng_wdata, datareceive}, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("t6_idle_grant", grant, 4'b0000);
        wb[3][0] = 8'h99;
        setreq(3, 7'h45, 1'b0, 4'd1, -1);
        tx_left[3] = 1;
        push_expect(3);
        req[3] = 1'b1;
        tick();
        chk("t6_grant_lat1", grant, 4'b0000);
        tick();
        chk("t6_grant3", grant, 4'b1000);
        wait_done(13);

        repeat (5) tick();
        chk("left_cmd",  q_cmd.size(), 0);
        chk("left_snd",  q_snd.size(), 0);
        chk("left_rcv",  q_rcv.size(), 0);
        chk("left_done", q_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
